// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
// Register numbers, FSM state encoding and the bundled control-word type.
package pipe_hazard_ctrl_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] reg_num_t;

    localparam reg_num_t REG_ZERO = '0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } state_t;

    // One decoded control word; hold drives every downstream stage-register hold.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic hold;
        logic halted;
    } ctrl_t;

    function automatic ctrl_t ctrl_frozen(input logic halted);
        ctrl_t c;
        c.pc_write    = 1'b0;
        c.ifid_write  = 1'b0;
        c.ifid_flush  = 1'b0;
        c.idex_bubble = 1'b0;
        c.hold        = 1'b1;
        c.halted      = halted;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the hazard controller and the pipeline datapath.
// master = controller side, slave = datapath side.
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
);
    reg_num_t         ifid_rs_i;
    reg_num_t         ifid_rt_i;
    logic             ifid_uses_rt_i;
    logic             idex_memread_i;
    reg_num_t         idex_rt_i;
    logic             branch_taken_i;
    logic             halt_instr_i;
    logic             imem_busy_i;
    logic             dmem_busy_i;

    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             idex_halt_o;
    logic             exmem_halt_o;
    logic             memwb_halt_o;
    logic             halted_o;
    logic             error_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        input  ifid_rs_i, ifid_rt_i, ifid_uses_rt_i, idex_memread_i, idex_rt_i,
               branch_taken_i, halt_instr_i, imem_busy_i, dmem_busy_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
               idex_halt_o, exmem_halt_o, memwb_halt_o, halted_o, error_o, stall_cnt_o
    );

    modport slave (
        output ifid_rs_i, ifid_rt_i, ifid_uses_rt_i, idex_memread_i, idex_rt_i,
               branch_taken_i, halt_instr_i, imem_busy_i, dmem_busy_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
               idex_halt_o, exmem_halt_o, memwb_halt_o, halted_o, error_o, stall_cnt_o
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Load-use hazard compare: a load in EX whose destination feeds a source of ID.
// Writes to register zero never create a dependency.
module hazard_cmp
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic     memread,
    input  reg_num_t idex_rt,
    input  reg_num_t ifid_rs,
    input  reg_num_t ifid_rt,
    input  logic     uses_rt,
    output logic     load_use
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (idex_rt == ifid_rs);
    assign rt_match = uses_rt && (idex_rt == ifid_rt);
    assign load_use = memread && (idex_rt != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register sequencer: load-use stalls, branch flush, memory freeze,
// HALT drain, saturating stall counter and sticky memory-timeout error.
//
// state    | meaning
// RUN      | normal issue; hazards, branches and HALT decoded here
// MEM_WAIT | memory busy, whole pipe frozen; resumes to ret_state
// DRAIN    | HALT seen, bubbles pushed until EX/MEM/WB are empty
// HALTED   | pipe stopped (drain done or memory timeout); leave via reset
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pipe_hazard_ctrl_if.master bus
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_t           state;
    state_t           state_nx;
    state_t           ret_state;
    state_t           ret_nx;
    state_t           eff_state;
    logic [DW-1:0]    drain_cnt;
    logic [DW-1:0]    drain_nx;
    logic [TW-1:0]    tmo_cnt;
    logic [TW-1:0]    tmo_nx;
    logic             error_q;
    logic             error_nx;
    logic [CNT_W-1:0] stall_cnt;
    logic             freeze;
    logic             load_use;
    ctrl_t            ctrl;

    hazard_cmp u_hazard_cmp (
        .memread  (bus.idex_memread_i),
        .idex_rt  (bus.idex_rt_i),
        .ifid_rs  (bus.ifid_rs_i),
        .ifid_rt  (bus.ifid_rt_i),
        .uses_rt  (bus.ifid_uses_rt_i),
        .load_use (load_use)
    );

    assign freeze = bus.imem_busy_i | bus.dmem_busy_i;

    // The cycle memory becomes ready already behaves as the state we return to,
    // so no issue/drain slot is lost on resume.
    assign eff_state = (state == ST_MEM_WAIT && !freeze) ? ret_state : state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_RUN;
            ret_state <= ST_RUN;
            drain_cnt <= '0;
            tmo_cnt   <= '0;
            error_q   <= 1'b0;
        end else begin
            state     <= state_nx;
            ret_state <= ret_nx;
            drain_cnt <= drain_nx;
            tmo_cnt   <= tmo_nx;
            error_q   <= error_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ret_nx   = ret_state;
        drain_nx = drain_cnt;
        tmo_nx   = tmo_cnt;
        error_nx = error_q;
        if (state != ST_HALTED) begin
            if (freeze) begin
                if (state == ST_MEM_WAIT) begin
                    if (tmo_cnt >= TW'(MEM_TIMEOUT - 1)) begin
                        error_nx = 1'b1;
                        state_nx = ST_HALTED;
                    end else begin
                        tmo_nx = tmo_cnt + 1'b1;
                    end
                end else begin
                    ret_nx   = state;
                    state_nx = ST_MEM_WAIT;
                    tmo_nx   = TW'(1);
                end
            end else begin
                tmo_nx = '0;
                case (eff_state)
                    ST_RUN: begin
                        state_nx = ST_RUN;
                        if (!load_use && bus.halt_instr_i) begin
                            state_nx = ST_DRAIN;
                            drain_nx = DW'(DRAIN_CYCLES);
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_cnt == DW'(1)) begin
                            state_nx = ST_HALTED;
                        end else begin
                            state_nx = ST_DRAIN;
                            drain_nx = drain_cnt - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        ctrl.pc_write    = 1'b1;
        ctrl.ifid_write  = 1'b1;
        ctrl.ifid_flush  = 1'b0;
        ctrl.idex_bubble = 1'b0;
        ctrl.hold        = 1'b0;
        ctrl.halted      = 1'b0;
        if (rst_i) begin
            ctrl = ctrl_frozen(1'b0);
        end else if (state == ST_HALTED) begin
            ctrl = ctrl_frozen(1'b1);
        end else if (freeze) begin
            ctrl = ctrl_frozen(1'b0);
        end else begin
            case (eff_state)
                ST_DRAIN: begin
                    ctrl.pc_write    = 1'b0;
                    ctrl.ifid_write  = 1'b0;
                    ctrl.idex_bubble = 1'b1;
                end
                ST_RUN: begin
                    if (load_use) begin
                        ctrl.pc_write    = 1'b0;
                        ctrl.ifid_write  = 1'b0;
                        ctrl.idex_bubble = 1'b1;
                    end else if (bus.halt_instr_i) begin
                        // IF/ID still loads, but it loads the flush NOP.
                        ctrl.pc_write    = 1'b0;
                        ctrl.ifid_flush  = 1'b1;
                        ctrl.idex_bubble = 1'b1;
                    end else if (bus.branch_taken_i) begin
                        ctrl.ifid_flush = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (!ctrl.pc_write && state != ST_HALTED && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.pc_write_o    = ctrl.pc_write;
    assign bus.ifid_write_o  = ctrl.ifid_write;
    assign bus.ifid_flush_o  = ctrl.ifid_flush;
    assign bus.idex_bubble_o = ctrl.idex_bubble;
    assign bus.idex_halt_o   = ctrl.hold;
    assign bus.exmem_halt_o  = ctrl.hold;
    assign bus.memwb_halt_o  = ctrl.hold;
    assign bus.halted_o      = ctrl.halted;
    assign bus.error_o       = error_q;
    assign bus.stall_cnt_o   = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic, all checked
// against a cycle-level behavioural model; a CNT_W=4 copy covers counter saturation.
module tb_pipe_hazard_ctrl;

    localparam int DRAIN = 3;
    localparam int TMO   = 255;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       memread;
        logic [4:0] xrt;
        logic       br;
        logic       hlt;
        logic       ib;
        logic       db;
    } stim_t;

    logic clk_i = 1'b0;
    logic rst_i;

    always #5 clk_i = ~clk_i;

    pipe_hazard_ctrl_if #(.CNT_W(16)) bus16 ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  bus4 ();

    assign bus4.ifid_rs_i      = bus16.ifid_rs_i;
    assign bus4.ifid_rt_i      = bus16.ifid_rt_i;
    assign bus4.ifid_uses_rt_i = bus16.ifid_uses_rt_i;
    assign bus4.idex_memread_i = bus16.idex_memread_i;
    assign bus4.idex_rt_i      = bus16.idex_rt_i;
    assign bus4.branch_taken_i = bus16.branch_taken_i;
    assign bus4.halt_instr_i   = bus16.halt_instr_i;
    assign bus4.imem_busy_i    = bus16.imem_busy_i;
    assign bus4.dmem_busy_i    = bus16.dmem_busy_i;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .MEM_TIMEOUT(TMO), .CNT_W(16)) u_dut16 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus16)
    );

    pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .MEM_TIMEOUT(TMO), .CNT_W(4)) u_dut4 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus4)
    );

    int tests = 0;
    int fails = 0;

    // behavioural model: halted flag, bubbles still owed, busy run length, stall total
    bit m_halted;
    int m_drain;
    int m_busy;
    bit m_err;
    int m_stalls;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic step(input stim_t s);
        logic lu, busy;
        logic e_pc, e_ifw, e_fl, e_bub, e_hold, e_hlt;
        bit   n_halted, n_err;
        int   n_drain, n_busy, n_stalls;

        rst_i                = s.rst;
        bus16.ifid_rs_i      = s.rs;
        bus16.ifid_rt_i      = s.rt;
        bus16.ifid_uses_rt_i = s.uses_rt;
        bus16.idex_memread_i = s.memread;
        bus16.idex_rt_i      = s.xrt;
        bus16.branch_taken_i = s.br;
        bus16.halt_instr_i   = s.hlt;
        bus16.imem_busy_i    = s.ib;
        bus16.dmem_busy_i    = s.db;
        #4;

        lu   = s.memread && (s.xrt != 5'd0) && ((s.xrt == s.rs) || (s.uses_rt && s.xrt == s.rt));
        busy = s.ib || s.db;
        e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_hold = 0; e_hlt = 0;
        n_halted = m_halted; n_err = m_err; n_drain = m_drain; n_busy = m_busy;
        n_stalls = m_stalls;

        if (s.rst) begin
            e_pc = 0; e_ifw = 0; e_hold = 1;
            n_halted = 0; n_err = 0; n_drain = 0; n_busy = 0; n_stalls = 0;
        end else if (m_halted) begin
            e_pc = 0; e_ifw = 0; e_hold = 1; e_hlt = 1;
        end else if (busy) begin
            e_pc = 0; e_ifw = 0; e_hold = 1;
            n_busy = m_busy + 1;
            if (n_busy >= TMO) begin
                n_err = 1; n_halted = 1;
            end
        end else begin
            n_busy = 0;
            if (m_drain > 0) begin
                e_pc = 0; e_ifw = 0; e_bub = 1;
                n_drain = m_drain - 1;
                if (n_drain == 0) n_halted = 1;
            end else if (lu) begin
                e_pc = 0; e_ifw = 0; e_bub = 1;
            end else if (s.hlt) begin
                e_pc = 0; e_fl = 1; e_bub = 1;
                n_drain = DRAIN;
            end else if (s.br) begin
                e_fl = 1;
            end
        end
        if (!s.rst && !m_halted && !e_pc) n_stalls = m_stalls + 1;

        chk("pc_write",    bus16.pc_write_o,    e_pc);
        chk("ifid_write",  bus16.ifid_write_o,  e_ifw);
        chk("ifid_flush",  bus16.ifid_flush_o,  e_fl);
        chk("idex_bubble", bus16.idex_bubble_o, e_bub);
        chk("idex_halt",   bus16.idex_halt_o,   e_hold);
        chk("exmem_halt",  bus16.exmem_halt_o,  e_hold);
        chk("memwb_halt",  bus16.memwb_halt_o,  e_hold);
        chk("halted",      bus16.halted_o,      e_hlt);
        chk("error",       bus16.error_o,       m_err);
        chk("stall_cnt16", bus16.stall_cnt_o,   (m_stalls > 65535) ? 65535 : m_stalls);
        chk("stall_cnt4",  bus4.stall_cnt_o,    (m_stalls > 15) ? 15 : m_stalls);
        chk("pc_write4",   bus4.pc_write_o,     e_pc);
        chk("halted4",     bus4.halted_o,       e_hlt);
        chk("error4",      bus4.error_o,        m_err);

        @(posedge clk_i);
        #1;
        m_halted = n_halted; m_err = n_err; m_drain = n_drain;
        m_busy = n_busy; m_stalls = n_stalls;
    endtask

    initial begin
        stim_t s;

        // untracked reset so registered outputs are defined before modelling starts
        rst_i = 1'b1;
        bus16.ifid_rs_i = '0; bus16.ifid_rt_i = '0; bus16.ifid_uses_rt_i = 1'b0;
        bus16.idex_memread_i = 1'b0; bus16.idex_rt_i = '0; bus16.branch_taken_i = 1'b0;
        bus16.halt_instr_i = 1'b0; bus16.imem_busy_i = 1'b0; bus16.dmem_busy_i = 1'b0;
        @(posedge clk_i);
        #1;
        m_halted = 0; m_drain = 0; m_busy = 0; m_err = 0; m_stalls = 0;

        s = idle(); s.rst = 1; step(s);
        step(idle());

        // load-use on rs
        s = idle(); s.memread = 1; s.xrt = 5; s.rs = 5; step(s);
        chk("lu_stall_cnt", bus16.stall_cnt_o, 1);
        step(idle());

        // r0 never hazards; rt match ignored when rt is not a source
        s = idle(); s.memread = 1; s.xrt = 0; s.rs = 0; step(s);
        s = idle(); s.memread = 1; s.xrt = 7; s.rt = 7; s.rs = 3; s.uses_rt = 0; step(s);
        s = idle(); s.memread = 1; s.xrt = 7; s.rt = 7; s.rs = 3; s.uses_rt = 1; step(s);

        // load-use beats branch, branch taken next cycle
        s = idle(); s.memread = 1; s.xrt = 9; s.rs = 9; s.br = 1; step(s);
        s = idle(); s.br = 1; step(s);

        // HALT, one drain bubble, freeze 4 cycles, then finish draining
        s = idle(); s.hlt = 1; step(s);
        step(idle());
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.db = 1; s.br = 1; step(s);
        end
        step(idle());
        chk("drain_not_yet_halted", bus16.halted_o, 0);
        step(idle());
        chk("drain_halted", bus16.halted_o, 1);
        step(idle());

        // memory timeout
        s = idle(); s.rst = 1; step(s);
        for (int i = 0; i < TMO; i++) begin
            s = idle(); s.ib = 1; step(s);
        end
        chk("tmo_error", bus16.error_o, 1);
        chk("tmo_halted", bus16.halted_o, 1);
        step(idle());
        s = idle(); s.rst = 1; step(s);
        chk("tmo_clr_error", bus16.error_o, 0);
        chk("tmo_clr_stall", bus16.stall_cnt_o, 0);
        step(idle());

        // reset in the middle of a drain
        s = idle(); s.hlt = 1; step(s);
        step(idle());
        s = idle(); s.rst = 1; step(s);
        step(idle());

        // saturation of the 4-bit counter
        s = idle(); s.rst = 1; step(s);
        for (int i = 0; i < 16; i++) begin
            s = idle(); s.memread = 1; s.xrt = 4; s.rt = 4; s.uses_rt = 1; step(s);
        end
        chk("sat4", bus4.stall_cnt_o, 15);
        chk("nosat16", bus16.stall_cnt_o, 16);

        // random traffic
        s = idle(); s.rst = 1; step(s);
        for (int i = 0; i < 3000; i++) begin
            s         = idle();
            s.rst     = ($urandom_range(0, 199) == 0);
            s.rs      = 5'($urandom_range(0, 7));
            s.rt      = 5'($urandom_range(0, 7));
            s.xrt     = 5'($urandom_range(0, 7));
            s.uses_rt = 1'($urandom_range(0, 1));
            s.memread = 1'($urandom_range(0, 1));
            s.br      = ($urandom_range(0, 3) == 0);
            s.hlt     = ($urandom_range(0, 39) == 0);
            s.ib      = ($urandom_range(0, 11) == 0);
            s.db      = ($urandom_range(0, 11) == 0);
            step(s);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
